// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display: active-low
// segment glyphs, the all-off anode pattern and a prescaler width helper.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Width needed to count 0..div-1; at least one bit even for tiny dividers.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational decoder from one BCD nibble to an active-low segment pattern;
// non-decimal nibbles render as a dash, and blank forces all segments off.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_7seg_mux.sv
// Four-digit common-anode display driver: shadows loaded BCD values, commits
// them only at frame boundaries, scans digits and blanks leading zeros.
module bcd_7seg_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            PW = presc_width(REFRESH_DIV);
  localparam logic [PW-1:0] TC = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_v;
  logic          tc;
  logic          boundary;
  logic [3:0]    lz;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;

  assign tc       = (prescaler == TC);
  assign boundary = tc && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= 2'd0;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the shadow and supersedes any
  // older pending value, so pend_v is cleared in that case too.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 16'h0000;
      pending <= 16'h0000;
      pend_v  <= 1'b0;
    end else if (load && boundary) begin
      active <= bcd_in;
      pend_v <= 1'b0;
    end else if (load) begin
      pending <= bcd_in;
      pend_v  <= 1'b1;
    end else if (boundary && pend_v) begin
      active <= pending;
      pend_v <= 1'b0;
    end
  end

  always_comb begin
    lz[3]  = (active[15:12] == 4'd0);
    lz[2]  = lz[3] && (active[11:8] == 4'd0);
    lz[1]  = lz[2] && (active[7:4] == 4'd0);
    lz[0]  = 1'b0;
    nibble = active[{idx, 2'b00} +: 4];
    blank  = BLANK_LZ && lz[idx];
  end

  bcd_to_seg u_dec (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_7seg_mux.sv
// Self-checking bench for bcd_7seg_mux with REFRESH_DIV=4, comparing two
// instances (blanking on/off) against a cycle-count based reference model.
module tb_bcd_7seg_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;

  int n_cmp = 0;
  int n_bad = 0;

  int          e;
  logic [15:0] act_m, pend_m;
  bit          pendv_m;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg, exp_seg_nb;

  logic [6:0] seen[4];
  logic [6:0] seen_nb[4];

  bcd_7seg_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .an(an), .seg(seg), .dp(dp)
  );

  bcd_7seg_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] glyph(input logic [15:0] v, input int slot, input bit lz);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = v >> (4 * slot);
    d     = upper[3:0];
    if (lz && slot > 0 && upper == 16'd0) return 7'b1111111;
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // e counts clock edges since reset release; digit slot and frame boundary
  // follow from it by plain arithmetic.
  always @(posedge clk) begin : model
    int slot;
    bit bnd;
    if (rst) begin
      e = 0; act_m = 16'h0; pend_m = 16'h0; pendv_m = 1'b0;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_seg_nb = 7'b1111111;
    end else begin
      slot       = (e / DIV) % 4;
      exp_an     = ~(4'b0001 << slot);
      exp_seg    = glyph(act_m, slot, 1'b1);
      exp_seg_nb = glyph(act_m, slot, 1'b0);
      bnd        = ((e % FRAME) == FRAME - 1);
      if (load && bnd) begin
        act_m = bcd_in; pendv_m = 1'b0;
      end else begin
        if (bnd && pendv_m) begin act_m = pend_m; pendv_m = 1'b0; end
        if (load) begin pend_m = bcd_in; pendv_m = 1'b1; end
      end
      e++;
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME + 1 && (e % FRAME) != p; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL reset_hold: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || an_nb !== 4'b1110 || seg_nb !== 7'b1000000) begin
      n_bad++;
      $display("[TB] FAIL reset_release: an=%b seg=%b nb_an=%b nb_seg=%b want 1110 1000000", an, seg, an_nb, seg_nb);
    end
    repeat (DIV - 1) @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110) begin
      n_bad++;
      $display("[TB] FAIL digit_hold: an=%b want 1110", an);
    end
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1101 || seg !== 7'b1111111 || seg_nb !== 7'b1000000) begin
      n_bad++;
      $display("[TB] FAIL digit_step: an=%b seg=%b nb_seg=%b want 1101 1111111 1000000", an, seg, seg_nb);
    end
  endtask

  task automatic test_display(input logic [15:0] v, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    int k;
    wait_phase(5);
    load = 1'b1; bcd_in = v;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < FRAME + 4 && (e % FRAME) != 0; i++) begin
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg || an_nb !== exp_an || seg_nb !== exp_seg_nb) begin
        n_bad++;
        $display("[TB] FAIL pre_wrap %h: an=%b seg=%b nb=%b want %b %b %b", v, an, seg, seg_nb, exp_an, exp_seg, exp_seg_nb);
      end
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin seen[j] = 7'bx; seen_nb[j] = 7'bx; end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || an_nb !== exp_an || seg_nb !== exp_seg_nb) begin
        n_bad++;
        $display("[TB] FAIL frame %h: an=%b seg=%b nb=%b want %b %b %b", v, an, seg, seg_nb, exp_an, exp_seg, exp_seg_nb);
      end
      k = slot_of(an);
      if (k >= 0) begin seen[k] = seg; seen_nb[k] = seg_nb; end
    end
    n_cmp++;
    if (seen[3] !== s3 || seen[2] !== s2 || seen[1] !== s1 || seen[0] !== s0) begin
      n_bad++;
      $display("[TB] FAIL glyphs %h: got %b %b %b %b want %b %b %b %b", v,
               seen[3], seen[2], seen[1], seen[0], s3, s2, s1, s0);
    end
    n_cmp++;
    if (seen_nb[3] !== glyph(v, 3, 1'b0) || seen_nb[2] !== glyph(v, 2, 1'b0) ||
        seen_nb[1] !== glyph(v, 1, 1'b0) || seen_nb[0] !== glyph(v, 0, 1'b0)) begin
      n_bad++;
      $display("[TB] FAIL glyphs_nolz %h: got %b %b %b %b", v, seen_nb[3], seen_nb[2], seen_nb[1], seen_nb[0]);
    end
  endtask

  task automatic test_tearing();
    int ones = 0;
    wait_phase(2);
    load = 1'b1; bcd_in = 16'h1111;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b1; bcd_in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("[TB] FAIL tearing: an=%b seg=%b want %b %b", an, seg, exp_an, exp_seg);
      end
      if (seg === 7'b1111001) ones++;
      @(negedge clk);
    end
    n_cmp++;
    if (ones != 0 || seg !== 7'b0100100) begin
      n_bad++;
      $display("[TB] FAIL tearing_stale: cycles_showing_1=%0d seg=%b want 0 0100100", ones, seg);
    end
  endtask

  task automatic test_boundary_load();
    int k;
    wait_phase(8);
    load = 1'b1; bcd_in = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    wait_phase(FRAME - 1);
    load = 1'b1; bcd_in = 16'h4321;
    @(negedge clk);
    load = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) seen[j] = 7'bx;
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        n_cmp++;
        if (an !== exp_an || seg !== exp_seg || seg_nb !== exp_seg_nb) begin
          n_bad++;
          $display("[TB] FAIL boundary_load: an=%b seg=%b want %b %b", an, seg, exp_an, exp_seg);
        end
        k = slot_of(an);
        if (k >= 0) seen[k] = seg;
      end
      n_cmp++;
      if (seen[3] !== 7'b0011001 || seen[2] !== 7'b0110000 || seen[1] !== 7'b0100100 || seen[0] !== 7'b1111001) begin
        n_bad++;
        $display("[TB] FAIL boundary_frame%0d: got %b %b %b %b want 4321", f, seen[3], seen[2], seen[1], seen[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 40 * FRAME; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || an_nb !== exp_an || seg_nb !== exp_seg_nb || dp_nb !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL random: an=%b seg=%b nb=%b want %b %b %b", an, seg, seg_nb, exp_an, exp_seg, exp_seg_nb);
      end
      load = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h0F0F;
        2: v = v & 16'h000F;
        default: ;
      endcase
      bcd_in = v;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int k;
    wait_phase(3);
    load = 1'b1; bcd_in = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    wait_phase(0);
    wait_phase(6);
    n_cmp++;
    if (seg !== 7'b0010000) begin
      n_bad++;
      $display("[TB] FAIL pre_reset: seg=%b want 0010000", seg);
    end
    load = 1'b1; bcd_in = 16'h5678;
    @(negedge clk);
    load = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || an_nb !== 4'b1111 || seg_nb !== 7'b1111111) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: an=%b seg=%b want 1111 1111111", an, seg);
    end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) seen[j] = 7'bx;
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        n_cmp++;
        if (an !== exp_an || seg !== exp_seg || seg_nb !== exp_seg_nb) begin
          n_bad++;
          $display("[TB] FAIL post_reset: an=%b seg=%b want %b %b", an, seg, exp_an, exp_seg);
        end
        k = slot_of(an);
        if (k >= 0) seen[k] = seg;
      end
      n_cmp++;
      if (seen[3] !== 7'b1111111 || seen[2] !== 7'b1111111 || seen[1] !== 7'b1111111 || seen[0] !== 7'b1000000) begin
        n_bad++;
        $display("[TB] FAIL post_reset_frame%0d: got %b %b %b %b want blank blank blank 0", f,
                 seen[3], seen[2], seen[1], seen[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0;
    test_reset();
    test_display(16'h1234, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    test_display(16'h0070, 7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000);
    test_display(16'h0A05, 7'b1111111, 7'b0111111, 7'b1000000, 7'b0010010);
    test_tearing();
    test_boundary_load();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_mux.md
Name: bcd_7seg_mux

Overview:
- Consumes the 16-bit packed BCD word from the binary-to-BCD converter and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Latches new values on a load strobe, which is normally the converter's ready pulse.
- Commits each new value only at a frame boundary, so the display never shows a mix of old and new digits.
- Scans the digits at a divided refresh rate, blanks leading zeros, and shows a dash for non-decimal nibbles.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is held (100 MHz gives 1 kHz per digit, 250 Hz per frame); minimum 2.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all four digits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; capture bcd_in.
- bcd_in  in  16  packed BCD; [15:12] thousands, [3:0] units.
- an  out  4  anode enables, active low; an[0] is the units digit.
- seg  out  7  segments, active low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active low; constant 1 (off).

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - prescaler=0, idx=0, active=16'h0000, pending=0, pend_v=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset overrides load and works mid-frame.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, idx (2-bit) increments mod 4.
  - Frame boundary = terminal count while idx==3, i.e. idx wraps 3→0.
- Load path:
  - load=1 captures bcd_in into pending and sets pend_v=1. There is no back-pressure; the last load before a boundary wins.
  - At a frame boundary with pend_v=1: active←pending, pend_v←0.
  - If load coincides with the boundary, bcd_in goes straight to active and pend_v stays 0.
- Output stage: an/seg are registered from the current idx and active, giving 1 cycle of latency after an idx change.
  - an = ~(4'b0001 << idx).
- Digit decode for nibble n:
  - 0–9 use standard patterns.
  - 10–15 show a dash (seg=7'b0111111, g only).
  - A blanked digit has seg=7'b1111111 and its anode is still driven.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit3 is blanked if d3==0.
  - Digit2 is blanked if d3==0 and d2==0.
  - Digit1 is blanked if d3, d2 and d1 are all 0.
  - Digit0 is never blanked, so a value of 0 shows "0".
  - A nibble >9 counts as nonzero.
- Timing: each digit is lit for exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles. A new value is visible at most one frame plus 1 cycle after load.
- First cycle after reset release: an=4'b1110, seg=7'b1000000 ("0").

Decomposition:
- Shared package bcd_disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (7-bit, active low);
  - AN_OFF=4'b1111;
  - a function computing the prescaler width from REFRESH_DIV.
- One combinational sub-module, bcd_to_seg: input nibble plus blank; output seg[6:0].
- Counters, the shadow register, the blanking logic and output registers stay in bcd_7seg_mux.

Test Plan (REFRESH_DIV=4, so the frame is 16 cycles):
- Reset: hold rst 3 cycles → an=1111, seg=1111111, dp=1. Release → next cycle an=1110, seg=1000000; an steps 1101 after 4 cycles.
- Load 16'h1234 mid-frame → digits unchanged until the 3→0 wrap, then per slot:
  - an=1110 seg=0011001 ("4");
  - an=1101 seg=0110000 ("3");
  - an=1011 seg=0100100 ("2");
  - an=0111 seg=1111001 ("1").
- Load 16'h0070 → an=0111 and an=1011 slots show seg=1111111; 1101 shows "7" (1111000); 1110 shows "0". With BLANK_LZ=0, all four digits show.
- Load 16'h0A05 → an=0111 blanked, 1011 shows dash 0111111, 1101 shows "0", 1110 shows "5".
- Tearing and simultaneity:
  - load 16'h1111 then 16'h2222 within one frame → only 2222 appears after the wrap; no frame ever shows 1111.
  - load asserted on the exact boundary cycle → that value is displayed in the immediately following frame.
- Reset mid-frame with 16'h9999 displayed and a pending load → all outputs off next cycle; display shows "0" after release; the pending value is discarded.
